// File: rtl/shuffle_pkg.sv
// shuffle_pkg: shared definitions for the shuffle permutation generator.
//   - state_e  : controller states
//   - msb_mask : smear of the highest set bit downwards (draw mask for index i)
//   - DEF_*    : default geometry; IDX_W / DRAWS derived from those defaults
package shuffle_pkg;

  localparam int DEF_LOG_N    = 3;
  localparam int DEF_WORDSIZE = 32;
  localparam int IDX_W        = DEF_LOG_N;
  localparam int DRAWS        = DEF_WORDSIZE / IDX_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_REFR = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_DRAW = 3'd5,
    S_OUT  = 3'd6
  } state_e;

  // All ones from bit 0 up to and including the MSB of v (0 for v == 0).
  function automatic logic [31:0] msb_mask(input logic [31:0] v);
    logic [31:0] m_s;
    m_s = v;
    m_s = m_s | (m_s >> 1);
    m_s = m_s | (m_s >> 2);
    m_s = m_s | (m_s >> 4);
    m_s = m_s | (m_s >> 8);
    m_s = m_s | (m_s >> 16);
    return m_s;
  endfunction

endpackage

// File: rtl/prng_word_fetch.sv
// prng_word_fetch: request/refresh handshake towards the PRNG wrapper.
//   fetch_i / refresh_i : controller is in its request / refresh state
//   wait_i              : controller is waiting for the wrapper
//   issued_o            : the pending request goes out this cycle
//   word_valid_o/word_o : one-cycle strobe with the captured PRNG word
//   refr_done_o         : one-cycle strobe, key refresh finished
//   prng_req_o/prng_refr_o : one-cycle pulses to the wrapper
module prng_word_fetch
  import shuffle_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_i,
  input  logic                refresh_i,
  input  logic                wait_i,
  input  logic                prng_busy_i,
  input  logic                prng_ready_i,
  input  logic [WORDSIZE-1:0] prng_word_i,
  output logic                issued_o,
  output logic                word_valid_o,
  output logic                refr_done_o,
  output logic [WORDSIZE-1:0] word_o,
  output logic                prng_req_o,
  output logic                prng_refr_o
);

  logic                req_r;
  logic                refr_r;
  logic                seen_r;
  logic                under_refr_r;
  logic                word_valid_r;
  logic                refr_done_r;
  logic [WORDSIZE-1:0] word_r;
  logic                issue_s;
  logic                done_s;

  // Issue when the wrapper is idle; complete only after busy was seen high and dropped.
  always_comb begin
    issue_s = 1'b0;
    done_s  = 1'b0;
    if ((fetch_i || refresh_i) && !prng_busy_i) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (wait_i && seen_r && !prng_busy_i && prng_ready_i) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Pulse generation, seen-busy flag, refresh tracking and word capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_r        <= 1'b0;
      refr_r       <= 1'b0;
      seen_r       <= 1'b0;
      under_refr_r <= 1'b0;
      word_valid_r <= 1'b0;
      refr_done_r  <= 1'b0;
      word_r       <= {WORDSIZE{1'b0}};
    end else begin
      req_r        <= fetch_i && issue_s;
      refr_r       <= refresh_i && !fetch_i && issue_s;
      // A completed refresh carries no usable word; it only reports completion.
      word_valid_r <= done_s && !under_refr_r;
      refr_done_r  <= done_s && under_refr_r;
      if (done_s || !wait_i) begin
        seen_r <= 1'b0;
      end else if (prng_busy_i) begin
        seen_r <= 1'b1;
      end else begin
        seen_r <= seen_r;
      end
      if (refresh_i && issue_s) begin
        under_refr_r <= 1'b1;
      end else if (done_s) begin
        under_refr_r <= 1'b0;
      end else begin
        under_refr_r <= under_refr_r;
      end
      if (done_s && !under_refr_r) begin
        word_r <= prng_word_i;
      end else begin
        word_r <= word_r;
      end
    end
  end

  assign issued_o     = issue_s;
  assign word_valid_o = word_valid_r;
  assign refr_done_o  = refr_done_r;
  assign word_o       = word_r;
  assign prng_req_o   = req_r;
  assign prng_refr_o  = refr_r;

endmodule

// File: rtl/shuffle_perm_gen.sv
// shuffle_perm_gen: Fisher-Yates permutation of 0..last_i using PRNG words,
// mask-and-reject sampling, streamed out over valid/ready.
//   start_i/last_i      : start a shuffle of length last_i+1 (idle only)
//   busy_o              : high whenever not idle
//   out_valid_o/out_ready_i/out_idx_o/out_last_o : permutation stream
//   prng_req_o/prng_refr_o/prng_word_i/prng_busy_i/prng_ready_i : PRNG wrapper
module shuffle_perm_gen
  import shuffle_pkg::*;
#(
  parameter int LOG_N          = DEF_LOG_N,
  parameter int WORDSIZE       = DEF_WORDSIZE,
  parameter int REFRESH_PERIOD = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [LOG_N-1:0]    last_i,
  output logic                busy_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [LOG_N-1:0]    out_idx_o,
  output logic                out_last_o,
  output logic                prng_req_o,
  output logic                prng_refr_o,
  input  logic [WORDSIZE-1:0] prng_word_i,
  input  logic                prng_busy_i,
  input  logic                prng_ready_i
);

  localparam int IW        = LOG_N;
  localparam int NUM_IDX   = 2 ** LOG_N;
  localparam int DRAW_BITS = (WORDSIZE / IW) * IW;
  localparam int BW        = $clog2(WORDSIZE + 1);
  localparam int PW        = $clog2(REFRESH_PERIOD + 1) + 1;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [IW-1:0]       last_r;
  logic [IW-1:0]       i_r;
  logic [IW-1:0]       k_r;
  logic [IW-1:0]       perm_r [NUM_IDX];
  logic [WORDSIZE-1:0] word_r;
  logic [BW-1:0]       bits_r;
  logic [PW-1:0]       pcnt_r;
  logic [IW-1:0]       mask_s;
  logic [IW-1:0]       cand_s;
  logic [IW-1:0]       i_dec_s;
  logic                accept_s;
  logic [BW-1:0]       bits_dec_s;
  logic                refr_due_s;
  logic                issued_s;
  logic                word_valid_s;
  logic                refr_done_s;
  logic [WORDSIZE-1:0] fetch_word_s;

  prng_word_fetch #(
    .WORDSIZE (WORDSIZE)
  ) u_fetch (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fetch_i      (state_r == S_REQ),
    .refresh_i    (state_r == S_REFR),
    .wait_i       (state_r == S_WAIT),
    .prng_busy_i  (prng_busy_i),
    .prng_ready_i (prng_ready_i),
    .prng_word_i  (prng_word_i),
    .issued_o     (issued_s),
    .word_valid_o (word_valid_s),
    .refr_done_o  (refr_done_s),
    .word_o       (fetch_word_s),
    .prng_req_o   (prng_req_o),
    .prng_refr_o  (prng_refr_o)
  );

  // Draw decode: masked candidate, accept test and the post-draw index/bit count.
  always_comb begin
    mask_s     = IW'(msb_mask(32'(i_r)));
    cand_s     = word_r[IW-1:0] & mask_s;
    accept_s   = (cand_s <= i_r);
    bits_dec_s = bits_r - BW'(IW);
    refr_due_s = (REFRESH_PERIOD != 0) && (pcnt_r == PW'(REFRESH_PERIOD));
    if (accept_s) begin
      i_dec_s = i_r - IW'(1);
    end else begin
      i_dec_s = i_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: if (start_i) state_nxt_s = S_INIT; else state_nxt_s = S_IDLE;
      S_INIT: begin
        if (last_r == {IW{1'b0}}) begin
          state_nxt_s = S_OUT;
        end else if (refr_due_s) begin
          state_nxt_s = S_REFR;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_REFR: if (issued_s) state_nxt_s = S_WAIT; else state_nxt_s = S_REFR;
      S_REQ:  if (issued_s) state_nxt_s = S_WAIT; else state_nxt_s = S_REQ;
      S_WAIT: begin
        if (word_valid_s) begin
          state_nxt_s = S_DRAW;
        end else if (refr_done_s) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DRAW: begin
        if (i_dec_s == {IW{1'b0}}) begin
          state_nxt_s = S_OUT;
        end else if (bits_dec_s < BW'(IW)) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_DRAW;
        end
      end
      S_OUT: begin
        if (out_ready_i && (k_r == last_r)) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: latch request, initialise/swap the permutation, consume draws, stream out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_r <= {IW{1'b0}};
      i_r    <= {IW{1'b0}};
      k_r    <= {IW{1'b0}};
      word_r <= {WORDSIZE{1'b0}};
      bits_r <= {BW{1'b0}};
      pcnt_r <= {PW{1'b0}};
      for (int k = 0; k < NUM_IDX; k++) begin
        perm_r[k] <= {IW{1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            last_r <= last_i;
            i_r    <= last_i;
            bits_r <= {BW{1'b0}};
            k_r    <= {IW{1'b0}};
          end
        end
        S_INIT: begin
          for (int k = 0; k < NUM_IDX; k++) begin
            perm_r[k] <= IW'(k);
          end
        end
        S_REFR: begin
          if (issued_s) pcnt_r <= {PW{1'b0}};
        end
        S_WAIT: begin
          if (word_valid_s) begin
            word_r <= fetch_word_s;
            bits_r <= BW'(DRAW_BITS);
          end
        end
        S_DRAW: begin
          word_r <= word_r >> IW;
          bits_r <= bits_dec_s;
          // cand == i writes the same value twice, i.e. a no-op swap.
          if (accept_s) begin
            perm_r[i_r]    <= perm_r[cand_s];
            perm_r[cand_s] <= perm_r[i_r];
          end
          i_r <= i_dec_s;
          if ((i_dec_s == {IW{1'b0}}) && (pcnt_r != {PW{1'b1}})) begin
            pcnt_r <= pcnt_r + PW'(1);
          end
        end
        S_OUT: begin
          if (out_ready_i) k_r <= k_r + IW'(1);
        end
        default: begin
          k_r <= k_r;
        end
      endcase
    end
  end

  // Output decode from registered state; everything reads 0 outside S_OUT.
  always_comb begin
    busy_o      = (state_r != S_IDLE);
    out_valid_o = (state_r == S_OUT);
    out_idx_o   = {IW{1'b0}};
    out_last_o  = 1'b0;
    if (state_r == S_OUT) begin
      out_idx_o  = perm_r[k_r];
      out_last_o = (k_r == last_r);
    end else begin
      out_idx_o  = {IW{1'b0}};
      out_last_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_shuffle_perm_gen.sv
// Self-checking bench for shuffle_perm_gen (LOG_N=3, WORDSIZE=32, REFRESH_PERIOD=2).
// Directed table vectors, reset-abort sequences and randomised shuffles checked
// against a plain Fisher-Yates reference model fed with the words the PRNG model delivered.
module tb_shuffle_perm_gen;

  localparam int N  = 8;
  localparam int RP = 2;
  localparam int DR = 32 / 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  last_i = 3'd0;
  logic        busy_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [2:0]  out_idx_o;
  logic        out_last_o;
  logic        prng_req_o;
  logic        prng_refr_o;
  logic [31:0] prng_word_i;
  logic        prng_busy_i;
  logic        prng_ready_i;

  always #5 clk_i = ~clk_i;

  shuffle_perm_gen #(.LOG_N(3), .WORDSIZE(32), .REFRESH_PERIOD(RP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .last_i(last_i),
    .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_idx_o(out_idx_o), .out_last_o(out_last_o),
    .prng_req_o(prng_req_o), .prng_refr_o(prng_refr_o), .prng_word_i(prng_word_i),
    .prng_busy_i(prng_busy_i), .prng_ready_i(prng_ready_i)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          busy_len = 3;
  logic [31:0] word_q [$];
  logic [31:0] used_w [$];
  int          req_cnt = 0;
  int          refr_cnt = 0;
  int          refr_req_snap = 0;
  int          pdone = 0;

  logic [2:0]  got_idx [N];
  logic        got_last [N];
  int          got_n, busy_cyc, req_base, refr_base, used_base;
  int          model_p [N];

  typedef struct {
    int          last;
    int          rmode;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [23:0] perm;
    int          reqs;
    int          refrs;
    int          busy;
  } vec_t;
  vec_t tbl [5];

  // PRNG wrapper model: busy for a while after each pulse, then a word (requests only).
  initial begin
    bit          is_req;
    logic [31:0] w;
    prng_busy_i  = 1'b0;
    prng_ready_i = 1'b1;
    prng_word_i  = 32'd0;
    forever begin
      @(posedge clk_i); #1;
      if (prng_req_o || prng_refr_o) begin
        is_req = prng_req_o;
        prng_busy_i = 1'b1;
        repeat (is_req ? busy_len : 144) @(posedge clk_i);
        #1;
        if (is_req) begin
          if (word_q.size() > 0) w = word_q.pop_front();
          else w = $urandom;
          used_w.push_back(w);
          prng_word_i = w;
        end
        prng_busy_i = 1'b0;
      end
    end
  end

  // Pulse counters sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk_i);
      if (prng_req_o) req_cnt++;
      if (prng_refr_o) begin
        refr_cnt++;
        refr_req_snap = req_cnt;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o),      32'd0);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_idx"},   32'(out_idx_o),   32'd0);
    check({tag, "_last"},  32'(out_last_o),  32'd0);
    check({tag, "_req"},   32'(prng_req_o),  32'd0);
    check({tag, "_refr"},  32'(prng_refr_o), 32'd0);
  endtask

  // Reference: Fisher-Yates over the delivered words, smallest all-ones mask >= i.
  task automatic model_perm(input int last, input int base, output int nw);
    int i, w, cand, m, t;
    logic [31:0] word;
    for (int k = 0; k < N; k++) model_p[k] = k;
    i = last;
    w = base;
    while (i > 0 && w < used_w.size()) begin
      word = used_w[w];
      w++;
      for (int d = 0; d < DR && i > 0; d++) begin
        m = 0;
        while (m < i) m = m * 2 + 1;
        cand = int'((word >> (3 * d)) & 32'd7) & m;
        if (cand <= i) begin
          t = model_p[i]; model_p[i] = model_p[cand]; model_p[cand] = t;
          i--;
        end
      end
    end
    nw = w - base;
  endtask

  // One shuffle: rmode 0 = always ready, 1 = random ready, 2 = 5-cycle stall at element 3.
  task automatic run_shuffle(input int last, input int rmode);
    int   cyc, bp;
    bit   held, r, fin;
    logic [2:0] h_idx;
    logic h_last;
    got_n = 0; busy_cyc = 0;
    req_base = req_cnt; refr_base = refr_cnt; used_base = used_w.size();
    start_i = 1'b1; last_i = 3'(last);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    held = 1'b0; bp = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (held) begin
        check("hold_valid", 32'(out_valid_o), 32'd1);
        check("hold_idx",   32'(out_idx_o),   32'(h_idx));
        check("hold_last",  32'(out_last_o),  32'(h_last));
      end
      if (!busy_o) begin
        fin = 1'b1;
      end else begin
        busy_cyc++;
        if (rmode == 1) r = 1'($urandom_range(0, 1));
        else if (rmode == 2 && out_valid_o && got_n == 3 && bp < 5) begin r = 1'b0; bp++; end
        else r = 1'b1;
        out_ready_i = r;
        held = out_valid_o && !r;
        h_idx = out_idx_o; h_last = out_last_o;
        if (out_valid_o && r) begin
          if (got_n < N) begin got_idx[got_n] = out_idx_o; got_last[got_n] = out_last_o; end
          got_n++;
        end
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    out_ready_i = 1'b0;
    check("run_finished", 32'(busy_o), 32'd0);
    check("stream_len", 32'(got_n), 32'(last + 1));
  endtask

  // Random shuffle checked against the model, the refresh schedule and word usage.
  task automatic do_random(input int last, input int rmode);
    int nw;
    bit exp_rf;
    logic [7:0] seen;
    exp_rf = (last != 0) && (pdone == RP);
    if (exp_rf) pdone = 0;
    run_shuffle(last, rmode);
    model_perm(last, used_base, nw);
    seen = 8'd0;
    for (int p = 0; p <= last && p < got_n; p++) begin
      check("rnd_idx",  32'(got_idx[p]),  32'(model_p[p]));
      check("rnd_last", 32'(got_last[p]), 32'(p == last));
      seen[got_idx[p]] = 1'b1;
    end
    check("rnd_is_perm", 32'(seen), 32'((1 << (last + 1)) - 1));
    check("rnd_reqs",  32'(req_cnt - req_base),   32'(nw));
    check("rnd_refrs", 32'(refr_cnt - refr_base), 32'(exp_rf));
    if (last != 0) pdone++;
  endtask

  initial begin
    int rb, rfb, cyc, e;
    tbl[0] = '{7, 2, 1, 32'h0000_0000, 32'h0, {3'd0,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1}, 1, 0, -1};
    tbl[1] = '{7, 0, 2, 32'hFFFF_FFFF, 32'h0, {3'd7,3'd0,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1}, 2, 0, -1};
    tbl[2] = '{0, 0, 0, 32'h0000_0000, 32'h0, 24'd0, 0, 0, 2};
    tbl[3] = '{3, 0, 1, 32'h0000_0000, 32'h0, {12'd0,3'd0,3'd3,3'd2,3'd1}, 1, 1, -1};
    tbl[4] = '{2, 1, 1, 32'h0000_0007, 32'h0, {15'd0,3'd0,3'd2,3'd1}, 1, 0, -1};

    repeat (3) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      busy_len = 3;
      if (tbl[v].nw > 0) word_q.push_back(tbl[v].w0);
      if (tbl[v].nw > 1) word_q.push_back(tbl[v].w1);
      if (tbl[v].last != 0 && pdone == RP) pdone = 0;
      run_shuffle(tbl[v].last, tbl[v].rmode);
      for (int p = 0; p <= tbl[v].last && p < got_n; p++) begin
        e = int'((tbl[v].perm >> (3 * p)) & 24'h7);
        check("tbl_idx",  32'(got_idx[p]),  32'(e));
        check("tbl_last", 32'(got_last[p]), 32'(p == tbl[v].last));
      end
      check("tbl_reqs",  32'(req_cnt - req_base),   32'(tbl[v].reqs));
      check("tbl_refrs", 32'(refr_cnt - refr_base), 32'(tbl[v].refrs));
      if (tbl[v].refrs != 0) check("tbl_refr_first", 32'(refr_req_snap), 32'(req_base));
      if (tbl[v].busy >= 0) check("tbl_busy_cycles", 32'(busy_cyc), 32'(tbl[v].busy));
      if (tbl[v].last != 0) pdone++;
      repeat (2) @(posedge clk_i);
      #1;
    end

    // Reset while drawing (an all-ones word keeps the controller drawing for 10 cycles).
    busy_len = 2;
    word_q.push_back(32'hFFFF_FFFF);
    rb = req_cnt;
    start_i = 1'b1; last_i = 3'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0;
    while (req_cnt == rb && cyc < 200) begin @(posedge clk_i); #1; cyc++; end
    check("draw_req_seen", 32'(req_cnt), 32'(rb + 1));
    repeat (7) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1 check_zero("rst_draw");
    rb = req_cnt; rfb = refr_cnt;
    repeat (4) @(posedge clk_i);
    #1 check_zero("rst_draw_hold");
    rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("rst_draw_no_req",  32'(req_cnt),  32'(rb));
    check("rst_draw_no_refr", 32'(refr_cnt), 32'(rfb));
    pdone = 0;
    busy_len = 3;
    do_random(7, 0);

    // Reset while waiting on a long PRNG busy.
    busy_len = 20;
    rb = req_cnt;
    start_i = 1'b1; last_i = 3'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0;
    while (req_cnt == rb && cyc < 200) begin @(posedge clk_i); #1; cyc++; end
    check("wait_req_seen", 32'(req_cnt), 32'(rb + 1));
    repeat (5) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1 check_zero("rst_wait");
    rb = req_cnt; rfb = refr_cnt;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;
    check("rst_wait_no_req",  32'(req_cnt),  32'(rb));
    check("rst_wait_no_refr", 32'(refr_cnt), 32'(rfb));
    check("rst_wait_idle",    32'(busy_o),   32'd0);
    pdone = 0;
    busy_len = 3;
    do_random(5, 2);

    // Randomised shuffles.
    for (int n = 0; n < 200; n++) begin
      busy_len = $urandom_range(1, 4);
      do_random($urandom_range(0, 7), $urandom_range(0, 2));
      @(posedge clk_i); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
